// File: rtl/apollo_13_pio_in_pkg.sv
// Shared constants for the parallel I/O blocks: register map and edge-type encodings.
package apollo_13_pio_in_pkg;

   localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
   localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
   localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/apollo_13_pio_sync.sv
// Purpose: WIDTH-bit multi-flop synchronizer for asynchronous input pins.
// Latency: SYNC_STAGES clk edges from pin to dout.
// Backpressure: none; samples every cycle.
module apollo_13_pio_sync #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage [SYNC_STAGES];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= din;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign dout = stage[SYNC_STAGES-1];

endmodule

// File: rtl/apollo_13_pio_in.sv
// Purpose: Avalon-MM input PIO with sticky edge capture, irq mask and level irq.
// Latency: zero-wait-state reads; pin-to-capture SYNC_STAGES+1 edges... see bench.
// Backpressure: none; every access completes in the cycle it is presented.
module apollo_13_pio_in
   import apollo_13_pio_in_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int EDGE_TYPE   = EDGE_RISE,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] edges;
   logic [WIDTH-1:0] cap_clr;
   logic [WIDTH-1:0] edge_capture;
   logic [WIDTH-1:0] irq_mask;
   logic             wr_en;

   apollo_13_pio_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (in_port),
      .dout    (s)
   );

   generate
      if (WIDTH < 32) begin : g_unused_wdata
         logic unused_wdata;
         assign unused_wdata = &{1'b0, writedata[31:WIDTH]};
      end
   endgenerate

   assign wr_en = chipselect && !write_n;

   always_comb begin
      edges = s & ~d;
      if (EDGE_TYPE == EDGE_FALL) begin
         edges = ~s & d;
      end else if (EDGE_TYPE == EDGE_ANY) begin
         edges = s ^ d;
      end
   end

   assign cap_clr = (wr_en && address == PIO_ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

   // d resets to 0, so a pin held high through reset captures as a rising edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         d            <= '0;
         edge_capture <= '0;
         irq_mask     <= '0;
      end else begin
         d            <= s;
         edge_capture <= (edge_capture & ~cap_clr) | edges;
         if (wr_en && address == PIO_ADDR_IRQMASK) begin
            irq_mask <= writedata[WIDTH-1:0];
         end
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         PIO_ADDR_DATA:    readdata[WIDTH-1:0] = s;
         PIO_ADDR_IRQMASK: readdata[WIDTH-1:0] = irq_mask;
         PIO_ADDR_EDGECAP: readdata[WIDTH-1:0] = edge_capture;
         default:          readdata = '0;
      endcase
   end

   assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_apollo_13_pio_in.sv
// Drives rising, falling and any-edge instances from shared stimulus and compares them to a pin-history model.
module tb_apollo_13_pio_in;

   localparam int SYNC = 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [3:0]  in_port = 4'h0;
   logic [31:0] rd [3];
   logic [2:0]  irq_v;

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   apollo_13_pio_in #(.WIDTH(4), .EDGE_TYPE(0), .SYNC_STAGES(SYNC)) u_rise (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd[0]), .irq(irq_v[0]));

   apollo_13_pio_in #(.WIDTH(4), .EDGE_TYPE(1), .SYNC_STAGES(SYNC)) u_fall (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd[1]), .irq(irq_v[1]));

   apollo_13_pio_in #(.WIDTH(4), .EDGE_TYPE(2), .SYNC_STAGES(SYNC)) u_any (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd[2]), .irq(irq_v[2]));

   // Reference model: history of pin samples, one per clk edge, newest first.
   logic [3:0] hist [$];
   logic [3:0] mcap [3];
   logic [3:0] mmask;

   function automatic logic [3:0] edge_of(input int t, input logic [3:0] s, input logic [3:0] d);
      logic [3:0] r;
      case (t)
         0:       r = s & ~d;
         1:       r = ~s & d;
         default: r = s ^ d;
      endcase
      return r;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hist.delete();
         for (int k = 0; k <= SYNC; k++) hist.push_back(4'h0);
         for (int t = 0; t < 3; t++) mcap[t] = 4'h0;
         mmask = 4'h0;
      end else begin
         logic [3:0] clr;
         logic [3:0] s_now;
         logic [3:0] d_now;
         s_now = hist[SYNC-1];
         d_now = hist[SYNC];
         clr = (chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0;
         for (int t = 0; t < 3; t++) mcap[t] = (mcap[t] & ~clr) | edge_of(t, s_now, d_now);
         if (chipselect && !write_n && address == 2'd2) mmask = writedata[3:0];
         hist.push_front(in_port);
         void'(hist.pop_back());
      end
   end

   function automatic logic [31:0] exp_rd(input int t, input logic [1:0] a);
      logic [31:0] r;
      r = '0;
      case (a)
         2'd0:    r[3:0] = hist[SYNC-1];
         2'd2:    r[3:0] = mmask;
         2'd3:    r[3:0] = mcap[t];
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int t = 0; t < 3; t++) begin
         check($sformatf("rd[%0d]@a%0d", t, address), rd[t], exp_rd(t, address));
         check($sformatf("irq[%0d]", t), {31'd0, irq_v[t]}, {31'd0, |(mcap[t] & mmask)});
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      check_all();
   endtask

   task automatic set_addr(input logic [1:0] a);
      address = a;
      #1;
      check_all();
   endtask

   task automatic do_write(input logic [1:0] a, input logic [31:0] data);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = data;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = $urandom;
      #1;
      check_all();
   endtask

   initial begin
      // Reset with pins at 0xA: everything reads zero.
      in_port = 4'hA;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int a = 0; a < 4; a++) begin
         address = a[1:0];
         #1;
         check("reset_rd", rd[0], 32'h0);
         check("reset_irq", {31'd0, irq_v[0]}, 32'h0);
      end
      reset_n = 1'b1;
      cyc();
      cyc();
      set_addr(2'd0);
      check("data_after_2", rd[0], 32'hA);
      set_addr(2'd1);
      check("reserved", rd[0], 32'h0);
      set_addr(2'd3);
      cyc();
      check("powerup_rise", rd[0], 32'hA);
      check("powerup_fall", rd[1], 32'h0);
      check("powerup_any", rd[2], 32'hA);
      check("powerup_irq", {31'd0, irq_v[0]}, 32'h0);

      // Rising capture on bit 0 and irq, then write-1-to-clear.
      do_write(2'd2, 32'h1);
      do_write(2'd3, 32'hF);
      set_addr(2'd3);
      in_port = 4'hB;
      cyc();
      cyc();
      check("rise_not_yet", rd[0], 32'h0);
      cyc();
      check("rise_cap", rd[0], 32'h1);
      check("rise_irq", {31'd0, irq_v[0]}, 32'h1);
      do_write(2'd3, 32'h1);
      set_addr(2'd3);
      check("clr_irq", {31'd0, irq_v[0]}, 32'h0);

      // Edge detect on bit 2 coincides with a clear of bit 2: set wins.
      do_write(2'd2, 32'h4);
      in_port = 4'hF;
      cyc();
      cyc();
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = 2'd3;
      writedata  = 32'h4;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      #1;
      check("simul_bit", rd[0] & 32'h4, 32'h4);
      check("simul_irq", {31'd0, irq_v[0]}, 32'h1);
      check_all();

      // Falling then rising transition on bit 3.
      do_write(2'd2, 32'h0);
      do_write(2'd3, 32'hF);
      set_addr(2'd3);
      in_port = 4'h7;
      repeat (3) cyc();
      check("fall_rise_inst", rd[0], 32'h0);
      check("fall_fall_inst", rd[1], 32'h8);
      check("fall_any_inst", rd[2], 32'h8);
      do_write(2'd3, 32'hF);
      set_addr(2'd3);
      in_port = 4'hF;
      repeat (3) cyc();
      check("rise_rise_inst", rd[0], 32'h8);
      check("rise_fall_inst", rd[1], 32'h0);
      check("rise_any_inst", rd[2], 32'h8);

      // Masking: capture 0x6, mask 0x1 -> no irq; mask 0x4 -> irq.
      in_port = 4'h0;
      repeat (4) cyc();
      do_write(2'd3, 32'hF);
      in_port = 4'h6;
      repeat (3) cyc();
      do_write(2'd2, 32'h1);
      set_addr(2'd3);
      check("mask_cap", rd[0], 32'h6);
      check("mask_irq0", {31'd0, irq_v[0]}, 32'h0);
      do_write(2'd2, 32'h4);
      check("mask_irq1", {31'd0, irq_v[0]}, 32'h1);
      set_addr(2'd2);
      check("mask_rd", rd[0], 32'h4);

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         in_port    = 4'($urandom);
         address    = 2'($urandom);
         chipselect = 1'($urandom);
         write_n    = ($urandom_range(0, 3) != 0);
         writedata  = $urandom;
         #1;
         check_all();
         @(negedge clk);
      end
      chipselect = 1'b0;
      write_n    = 1'b1;

      // Reset mid-operation with capture 0xF and mask 0xF.
      in_port = 4'h0;
      repeat (4) cyc();
      do_write(2'd3, 32'hF);
      do_write(2'd2, 32'hF);
      in_port = 4'hF;
      repeat (3) cyc();
      set_addr(2'd3);
      check("pre_reset_cap", rd[0], 32'hF);
      check("pre_reset_irq", {31'd0, irq_v[0]}, 32'h1);
      in_port = 4'h0;
      #3;
      reset_n = 1'b0;
      #1;
      check("async_irq_rise", {31'd0, irq_v[0]}, 32'h0);
      check("async_irq_any", {31'd0, irq_v[2]}, 32'h0);
      check("async_cap", rd[0], 32'h0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) cyc();
      for (int a = 0; a < 4; a++) begin
         set_addr(a[1:0]);
         check("post_reset_rd", rd[0], 32'h0);
      end
      check("post_reset_irq", {31'd0, irq_v[0]}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
